// File: rtl/pong_pkg.sv
// Shared pong definitions: flash sequencer states and the paddle mask builder.
// The mask builder is also used by the collision logic, so it stays width-generic.
package pong_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FLASH = 2'd2
  } flash_state_t;

  // Ones in columns pos..pos+len-1; a paddle that would overhang the edge is not drawn.
  function automatic logic [MAX_W-1:0] paddle_mask(input int pos, input int len, input int width);
    logic [MAX_W-1:0] m;
    m = '0;
    if (pos <= width - len) begin
      for (int i = 0; i < MAX_W; i++) begin
        if (i >= pos && i < pos + len) m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Row scan counters: each row held ROW_HOLD cycles, HEIGHT rows per frame.
// Strobes are combinational from the counter registers; no backpressure.
module scan_timer #(
  parameter int HEIGHT   = 8,
  parameter int ROW_HOLD = 4,
  parameter int YW       = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [YW-1:0] row_cnt,
  output logic          frame_first,
  output logic          frame_wrap
);

  localparam int HW = (ROW_HOLD > 1) ? $clog2(ROW_HOLD) : 1;

  logic [HW-1:0] hold_cnt;
  logic          hold_last;
  logic          row_last;

  assign hold_last   = (hold_cnt == HW'(ROW_HOLD - 1));
  assign row_last    = (row_cnt == YW'(HEIGHT - 1));
  assign frame_wrap  = hold_last && row_last;
  assign frame_first = (row_cnt == '0) && (hold_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      row_cnt  <= '0;
    end else if (hold_last) begin
      hold_cnt <= '0;
      row_cnt  <= row_last ? '0 : row_cnt + 1'b1;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/matrix_scan_composer.sv
// LED matrix frame composer: row scan, per-frame position snapshot, paddles/ball, test and goal flash.
// Outputs registered one cycle behind the scan counters; free-running, no backpressure.
module matrix_scan_composer
  import pong_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int HEIGHT       = 8,
  parameter int PADDLE_LEN   = 2,
  parameter int ROW_HOLD     = 4,
  parameter int FLASH_FRAMES = 4,
  parameter int XW           = $clog2(WIDTH),
  parameter int YW           = $clog2(HEIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XW-1:0]    player_top,
  input  logic [XW-1:0]    player_down,
  input  logic [XW-1:0]    x_pos,
  input  logic [YW-1:0]    y_pos,
  input  logic             ball_en,
  input  logic             testled,
  input  logic             flash_req,
  output logic [YW-1:0]    row_out,
  output logic [WIDTH-1:0] matrix_out,
  output logic             frame_start,
  output logic             flashing
);

  localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  logic [YW-1:0] row_cnt;
  logic          frame_first;
  logic          frame_wrap;

  scan_timer #(
    .HEIGHT  (HEIGHT),
    .ROW_HOLD(ROW_HOLD),
    .YW      (YW)
  ) u_scan_timer (
    .clk        (clk),
    .rst        (rst),
    .row_cnt    (row_cnt),
    .frame_first(frame_first),
    .frame_wrap (frame_wrap)
  );

  logic [XW-1:0] snap_top;
  logic [XW-1:0] snap_down;
  logic [XW-1:0] snap_x;
  logic [YW-1:0] snap_y;
  logic          snap_en;

  // Latched on the last cycle of a frame so the next frame is drawn from one coherent set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_top  <= '0;
      snap_down <= '0;
      snap_x    <= '0;
      snap_y    <= '0;
      snap_en   <= 1'b0;
    end else if (frame_wrap) begin
      snap_top  <= player_top;
      snap_down <= player_down;
      snap_x    <= x_pos;
      snap_y    <= y_pos;
      snap_en   <= ball_en;
    end
  end

  flash_state_t  state;
  logic [FW-1:0] frame_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      frame_idx <= '0;
      flashing  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flash_req) begin
            state    <= ARMED;
            flashing <= 1'b1;
          end
        end
        ARMED: begin
          if (frame_wrap) begin
            state     <= FLASH;
            frame_idx <= '0;
          end
        end
        FLASH: begin
          if (frame_wrap) begin
            if (frame_idx == FW'(FLASH_FRAMES - 1)) begin
              state    <= IDLE;
              flashing <= 1'b0;
            end else begin
              frame_idx <= frame_idx + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          flashing <= 1'b0;
        end
      endcase
    end
  end

  logic [WIDTH-1:0] top_mask;
  logic [WIDTH-1:0] down_mask;
  logic [WIDTH-1:0] ball_mask;
  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] next_matrix;
  logic             blank;

  always_comb begin
    top_mask  = WIDTH'(paddle_mask(int'(snap_top), PADDLE_LEN, WIDTH));
    down_mask = WIDTH'(paddle_mask(int'(snap_down), PADDLE_LEN, WIDTH));
    ball_mask = '0;
    // Row compare also rejects y >= HEIGHT since row_cnt never reaches it.
    if (snap_en && (snap_y == row_cnt) && (int'(snap_x) < WIDTH)) begin
      ball_mask = WIDTH'(1) << snap_x;
    end
    pattern = ball_mask;
    if (row_cnt == '0) pattern = pattern | top_mask;
    if (row_cnt == YW'(HEIGHT - 1)) pattern = pattern | down_mask;
    blank = (state == FLASH) && frame_idx[0];
    if (testled) begin
      next_matrix = '1;
    end else if (blank) begin
      next_matrix = '0;
    end else begin
      next_matrix = pattern;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_out     <= '0;
      matrix_out  <= '0;
      frame_start <= 1'b0;
    end else begin
      row_out     <= row_cnt;
      matrix_out  <= next_matrix;
      frame_start <= frame_first;
    end
  end

endmodule

// File: tb/tb_matrix_scan_composer.sv
// Directed bench for matrix_scan_composer at default parameters (8x8, hold 4, 4 flash frames).
module tb_matrix_scan_composer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] player_top, player_down, x_pos, y_pos;
  logic       ball_en, testled, flash_req;
  logic [2:0] row_out;
  logic [7:0] matrix_out;
  logic       frame_start, flashing;

  always #5 clk = ~clk;

  matrix_scan_composer dut (
    .clk        (clk),
    .rst        (rst),
    .player_top (player_top),
    .player_down(player_down),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .ball_en    (ball_en),
    .testled    (testled),
    .flash_req  (flash_req),
    .row_out    (row_out),
    .matrix_out (matrix_out),
    .frame_start(frame_start),
    .flashing   (flashing)
  );

  typedef struct {
    int         frame;
    int         row;
    logic [7:0] pat;
  } exp_t;
  typedef logic [7:0] frame_t [8];

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cur_frame = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_frame(input int f, input frame_t p);
    for (int r = 0; r < 8; r++) q.push_back('{frame: f, row: r, pat: p[r]});
  endtask

  task automatic wait_frame();
    int f;
    int n;
    f = cur_frame;
    n = 0;
    while (cur_frame == f && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (cur_frame == f) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: no frame_start within %0d cycles", n);
    end
    #1;
  endtask

  task automatic pulse_flash();
    flash_req = 1'b1;
    @(posedge clk);
    #1 flash_req = 1'b0;
  endtask

  // Monitor: scan timing checks plus scoreboard pops at every row boundary.
  initial begin
    int last_row;
    int last_change;
    int last_fs;
    last_row = 0;
    last_change = -1;
    last_fs = -1;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_row = 0;
        last_change = -1;
        last_fs = -1;
      end else begin
        if (frame_start) begin
          cur_frame++;
          if (last_fs >= 0) check("frame_period", cyc - last_fs, 32);
          last_fs = cyc;
          check("frame_row0", int'(row_out), 0);
        end
        if (int'(row_out) != last_row || frame_start) begin
          if (int'(row_out) != last_row) begin
            if (last_change >= 0) check("row_hold", cyc - last_change, 4);
            check("row_step", int'(row_out), (last_row + 1) % 8);
            last_change = cyc;
            last_row = int'(row_out);
          end
          while (q.size() > 0 && q[0].frame < cur_frame) begin
            total++;
            bad++;
            $display("FAIL missed_row: frame %0d row %0d never shown, now frame %0d",
                     q[0].frame, q[0].row, cur_frame);
            void'(q.pop_front());
          end
          if (q.size() > 0 && q[0].frame == cur_frame && q[0].row == int'(row_out)) begin
            check($sformatf("row_pattern f%0d r%0d", q[0].frame, q[0].row),
                  int'(matrix_out), int'(q[0].pat));
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    frame_t p;
    frame_t nrm;
    frame_t zro;
    int     f0;

    player_top = 0; player_down = 0; x_pos = 0; y_pos = 0;
    ball_en = 0; testled = 0; flash_req = 0;
    #1 rst = 1'b1;
    #1;
    check("reset_row_out", int'(row_out), 0);
    check("reset_matrix_out", int'(matrix_out), 0);
    check("reset_frame_start", int'(frame_start), 0);
    check("reset_flashing", int'(flashing), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // First frame after reset draws the all-zero snapshot.
    p = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03};
    push_frame(cur_frame + 1, p);

    wait_frame();
    player_top = 3; player_down = 6; x_pos = 5; y_pos = 4; ball_en = 1;
    p = '{8'h18, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'hC0};
    push_frame(cur_frame + 1, p);

    wait_frame();
    player_top = 7;
    p = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'hC0};
    push_frame(cur_frame + 1, p);

    wait_frame();
    player_top = 0; player_down = 7; x_pos = 1; y_pos = 0;
    p = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    push_frame(cur_frame + 1, p);

    wait_frame();
    player_top = 3; player_down = 6; x_pos = 5; y_pos = 4;
    p = '{8'h18, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'hC0};
    push_frame(cur_frame + 1, p);

    // Mid-frame x change: this frame keeps 0x20 on row 4, the next one moves the ball.
    wait_frame();
    repeat (10) @(posedge clk);
    #1 x_pos = 2;
    p = '{8'h18, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'hC0};
    push_frame(cur_frame + 1, p);

    wait_frame();
    ball_en = 0;
    p = '{8'h18, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0};
    push_frame(cur_frame + 1, p);

    // Goal flash: normal, blank, normal, blank, then back to normal.
    nrm = '{8'h18, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'hC0};
    zro = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    wait_frame();
    ball_en = 1; x_pos = 5;
    check("flashing_idle", int'(flashing), 0);
    pulse_flash();
    check("flashing_rise", int'(flashing), 1);
    f0 = cur_frame;
    push_frame(f0 + 1, nrm);
    push_frame(f0 + 2, zro);
    push_frame(f0 + 3, nrm);
    push_frame(f0 + 4, zro);
    push_frame(f0 + 5, nrm);
    wait_frame();
    check("flashing_f1", int'(flashing), 1);
    wait_frame();
    pulse_flash();
    wait_frame();
    wait_frame();
    check("flashing_f4", int'(flashing), 1);
    wait_frame();
    check("flashing_fall", int'(flashing), 0);

    // testled over a blank flash frame, then reset in the middle of the flash.
    pulse_flash();
    f0 = cur_frame;
    push_frame(f0 + 1, nrm);
    q.push_back('{frame: f0 + 2, row: 0, pat: 8'h00});
    wait_frame();
    wait_frame();
    testled = 1;
    check("testled_lag", int'(matrix_out), 8'h00);
    @(posedge clk);
    #1 check("testled_on", int'(matrix_out), 8'hFF);
    repeat (4) @(posedge clk);
    #1 testled = 0;
    @(posedge clk);
    #1 check("testled_off_blank", int'(matrix_out), 8'h00);
    rst = 1'b1;
    #1;
    check("rst_flashing", int'(flashing), 0);
    check("rst_matrix_out", int'(matrix_out), 0);
    check("rst_row_out", int'(row_out), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    p = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03};
    push_frame(cur_frame + 1, p);
    wait_frame();
    wait_frame();
    check("post_reset_flashing", int'(flashing), 0);
    check("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
